// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: shared state type, switch polarity constant and BCD digit-vector helpers
package chess_clock_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        FLAG  = 3'd4,
        WON   = 3'd5
    } t_player_state;
    localparam logic PULLUP = 1'b1;
    localparam int MAX_DIGITS = 16;
    typedef logic [4*MAX_DIGITS-1:0] t_bcd_vec;
    // digits at index n and above must be zero; a zero vector stays zero
    function automatic t_bcd_vec bcd_dec(input t_bcd_vec v, input int n);
        t_bcd_vec r;
        logic b;
        r = v;
        b = v != '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && b) begin
                if (v[4*i+:4] == 4'd0) r[4*i+:4] = 4'd9;
                else begin
                    r[4*i+:4] = v[4*i+:4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction
    function automatic t_bcd_vec bcd_add_sat(input t_bcd_vec a, input t_bcd_vec b, input int n);
        t_bcd_vec r;
        logic [4:0] s;
        logic c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                s = 5'(a[4*i+:4]) + 5'(b[4*i+:4]) + 5'(c);
                c = s > 5'd9;
                r[4*i+:4] = c ? 4'(s - 5'd10) : s[3:0];
            end
        end
        for (int i = 0; i < MAX_DIGITS; i++)
            if (c && i < n) r[4*i+:4] = 4'd9;
        return r;
    endfunction
endpackage

// File: rtl/chess_clock_player_gen_if.sv
// chess_clock_player_gen_if: turn handshake between the game arbiter (master) and one player (slave)
interface chess_clock_player_gen_if;
    logic i_active;
    logic i_stop;
    logic i_win;
    logic o_turn;
    logic o_zero;
    modport master (output i_active, i_stop, i_win, input o_turn, o_zero);
    modport slave (input i_active, i_stop, i_win, output o_turn, o_zero);
endinterface

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: p_digits BCD counter with load, saturating add and a decrement that floors at zero
module bcd_counter_n import chess_clock_pkg::*; #(
    parameter int p_digits = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic [4*p_digits-1:0] i_load_val,
    input  logic i_add,
    input  logic [4*p_digits-1:0] i_add_val,
    input  logic i_dec,
    output logic [4*p_digits-1:0] o_cnt,
    output logic o_zero
);
    localparam int W = 4 * p_digits;
    logic [W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_add) r_cnt <= W'(bcd_add_sat(t_bcd_vec'(r_cnt), t_bcd_vec'(i_add_val), p_digits));
        else if (i_dec) r_cnt <= W'(bcd_dec(t_bcd_vec'(r_cnt), p_digits));
    end
    assign o_cnt = r_cnt;
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/clock.sv
// clock: prescaler that strobes o_tick on the last of every p_divider enabled cycles
module clock #(
    parameter int p_divider = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = (p_divider > 1) ? $clog2(p_divider) : 1;
    localparam logic [W-1:0] LAST = W'(p_divider - 1);
    logic [W-1:0] r_cnt;
    logic w_wrap;
    assign w_wrap = r_cnt == LAST;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
    end
    assign o_tick = i_en && w_wrap;
endmodule

// File: rtl/drv_segment_dec_w.sv
// drv_segment_dec_w: combinational BCD to active-high 7-segment (bit 0 = segment a), p_digits wide
module drv_segment_dec_w #(
    parameter int p_digits = 4
) (
    input  logic [p_digits-1:0][3:0] i_bcd,
    output logic [p_digits-1:0][6:0] o_sgmnt
);
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction
    always_comb
        for (int i = 0; i < p_digits; i++) o_sgmnt[i] = seg(i_bcd[i]);
endmodule

// File: rtl/drv_switch.sv
// drv_switch: synchronise and debounce a raw button, one-cycle o_click per accepted press
module drv_switch import chess_clock_pkg::*; #(
    parameter int p_scale = 16,
    parameter logic p_mode = PULLUP
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_click
);
    logic [1:0] r_sync;
    logic [p_scale-1:0] r_cnt;
    logic r_level;
    logic r_click;
    logic w_settled;
    assign w_settled = &r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt <= '0;
            r_level <= 1'b0;
            r_click <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_sw ^ p_mode};
            r_click <= w_settled && r_sync[1] && !r_level;
            if (r_sync[1] == r_level) r_cnt <= '0;
            else if (w_settled) begin
                r_level <= r_sync[1];
                r_cnt <= '0;
            end else r_cnt <= r_cnt + p_scale'(1);
        end
    end
    assign o_click = r_click;
endmodule

// File: rtl/chess_clock_player_gen.sv
// chess_clock_player_gen: one player's chess-clock timer with debounce, BCD countdown and Fischer bonus
module chess_clock_player_gen import chess_clock_pkg::*; #(
    parameter int p_divider = 50_000_000,
    parameter int p_scale = 3,
    parameter int p_digits = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_drv_sw,
    input  logic [p_digits-1:0][3:0] i_init,
    input  logic [p_digits-1:0][3:0] i_bonus,
    input  logic i_mode,
    input  logic i_load,
    chess_clock_player_gen_if.slave bus,
    output logic [p_digits-1:0][6:0] o_drv_sgmnt,
    output logic [3:0] o_drv_led,
    output logic [2:0] o_state
);
    t_player_state r_state, w_next;
    logic r_turn, r_act_q;
    logic w_click, w_tick, w_zero, w_run;
    logic w_add, w_dec, w_turn, w_clr;
    logic [4*p_digits-1:0] w_cnt;
    assign w_run = r_state == RUN;
    drv_switch #(.p_scale(p_scale), .p_mode(PULLUP)) u_sw (
        .i_clk(i_clk), .i_rst(i_rst), .i_sw(i_drv_sw), .o_click(w_click)
    );
    clock #(.p_divider(p_divider)) u_tick (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(w_clr), .i_en(w_run), .o_tick(w_tick)
    );
    bcd_counter_n #(.p_digits(p_digits)) u_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_load_val(i_init),
        .i_add(w_add), .i_add_val(i_bonus), .i_dec(w_dec), .o_cnt(w_cnt), .o_zero(w_zero)
    );
    drv_segment_dec_w #(.p_digits(p_digits)) u_seg (.i_bcd(w_cnt), .o_sgmnt(o_drv_sgmnt));
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_turn <= 1'b0;
            r_act_q <= 1'b0;
        end else begin
            r_state <= w_next;
            r_turn <= w_turn;
            r_act_q <= bus.i_active;
        end
    end
    // a counter already at zero flags before any click can rescue it
    always_comb begin
        w_next = r_state;
        w_turn = 1'b0;
        w_add = 1'b0;
        w_dec = 1'b0;
        w_clr = r_state == IDLE || r_state == WAIT;
        case (r_state)
            IDLE: w_next = bus.i_active ? RUN : IDLE;
            WAIT: w_next = (bus.i_active && !r_act_q) ? RUN : WAIT;
            RUN:
                if (w_zero) w_next = FLAG;
                else if (w_click) begin
                    w_turn = 1'b1;
                    w_add = i_mode;
                    w_next = WAIT;
                end else begin
                    w_dec = w_tick;
                    w_next = bus.i_stop ? PAUSE : bus.i_active ? RUN : WAIT;
                end
            PAUSE: w_next = bus.i_stop ? PAUSE : RUN;
            default: w_next = r_state;
        endcase
        if (bus.i_win && r_state != FLAG) begin
            w_next = WON;
            w_turn = 1'b0;
            w_add = 1'b0;
            w_dec = 1'b0;
        end
        if (i_load) begin
            w_next = IDLE;
            w_turn = 1'b0;
            w_add = 1'b0;
            w_dec = 1'b0;
            w_clr = 1'b1;
        end
    end
    assign bus.o_turn = r_turn;
    assign bus.o_zero = w_zero;
    assign o_state = r_state;
    assign o_drv_led = {r_state == WON, r_state == FLAG, r_state == PAUSE, r_state == RUN};
endmodule

// File: doc/chess_clock_player_gen.md
Name: chess_clock_player_gen

Overview:
- Parametrised per-player chess-clock timer with a configurable digit count and a Fischer-increment mode.
- Handles button debounce, BCD countdown, bonus add on turn end, pause/win/flag states, and drives the 7-segment display and status LEDs.
- Two instances sit under a game-level arbiter; the arbiter drives i_active and consumes o_turn and o_zero.

Parameters:
- p_divider, 50_000_000, i_clk cycles per time tick (1 s at 50 MHz).
- p_scale, 3, debounce scale passed to the switch driver.
- p_digits, 4, number of BCD digits on the counter and display (≥2).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_drv_sw  in  1  raw player button, pull-up (pressed = 0)
- i_init  in  [3:0] x p_digits  BCD initial time; index 0 = least significant digit
- i_bonus  in  [3:0] x p_digits  BCD increment added per completed turn
- i_mode  in  1  0 = sudden death, 1 = Fischer increment
- i_load  in  1  load i_init and return to IDLE
- i_active  in  1  this player's turn, from the arbiter
- i_stop  in  1  pause request
- i_win  in  1  opponent flagged; this player won
- o_drv_sgmnt  out  [6:0] x p_digits  segment patterns, active as the existing decimal segment driver
- o_drv_led  out  4  [0] running, [1] paused, [2] flagged, [3] won
- o_turn  out  1  one-cycle pulse on a turn-ending click
- o_zero  out  1  level; counter equals 0
- o_state  out  3  current FSM state encoding

Behaviour:
- Reset (i_rst=1 at a clock edge), including mid-operation:
  - state IDLE, counter all zeros, tick prescaler 0.
  - o_turn=0, o_drv_led=0.
  - o_zero=1, because the counter is zero.
- FSM states: IDLE, WAIT, RUN, PAUSE, FLAG, WON.
- i_load (highest priority after reset):
  - counter ← i_init, state ← IDLE, prescaler ← 0.
  - Honoured in every state.
- IDLE:
  - i_active=1 → RUN.
  - Otherwise hold.
- RUN:
  - Prescaler counts 0..p_divider-1. At wrap it issues a one-cycle tick that decrements the counter by 1 BCD (borrow across digits).
  - Counter reaches 0 → FLAG on the next edge.
  - Click → o_turn pulses one cycle; in mode 1 the counter gains i_bonus; state ← WAIT.
  - i_stop=1 → PAUSE. The prescaler holds its value and is not cleared.
  - i_active=0 without a click → WAIT (arbiter override); no o_turn.
- WAIT:
  - i_active rising into a level 1 → RUN.
  - Prescaler cleared on entry, so the first tick of a new turn arrives exactly p_divider cycles after RUN entry.
- PAUSE:
  - i_stop=0 → RUN, resuming the prescaler.
  - Clicks are ignored.
- FLAG:
  - Counter frozen at 0, o_zero=1.
  - Only i_load or reset exits.
- WON:
  - Entered from any state except FLAG when i_win=1.
  - Counter frozen; only i_load or reset exits.
- Click definition: the o_click pulse of the debounced switch driver (p_mode PULLUP). Clicks in any state other than RUN are dropped and do not pulse o_turn.
- Same-cycle priority (highest first): i_rst > i_load > i_win > click > tick > i_stop.
  - Click and tick in the same cycle: click wins and the tick is discarded. A player at 1 who clicks on the tick cycle does not flag.
- Bonus add:
  - BCD addition, saturating at all-9s (no wrap).
  - Mode 0 never adds.
  - i_bonus=0 in mode 1 gives no change.
- The decrement never underflows below 0.
- The display is combinational from the counter. LEDs are combinational from the state.
- Latency:
  - Click press → o_turn is debounce latency + 1 cycle.
  - Counter update is 1 cycle after the tick or click.

Decomposition:
- Package chess_clock_pkg holds:
  - state enum t_player_state;
  - the PULLUP constant;
  - BCD helper functions bcd_dec and bcd_add_sat on a digit vector.
- Sub-module bcd_counter_n (p_digits) provides load, decrement, saturating add and a zero flag.
- Instantiate the existing drv_switch, clock and drv_segment_dec_w.

Test Plan:
All scenarios use p_divider=4, p_digits=2, p_scale minimal.
- Load init 05, i_active=1 → counter 04, 03, 02, 01, 00 every 4 cycles; o_zero=1 and state FLAG; further ticks hold 00.
- Mode 1, bonus 03, counter 10, click in RUN → o_turn single pulse, counter 13, state WAIT; click in WAIT gives no pulse.
- Counter 98, bonus 05, click → counter 99 (saturated).
- i_stop for 10 cycles mid-prescaler → counter unchanged and LED[1]=1; release → next tick arrives after the remaining prescaler count.
- Counter 01, click and tick in the same cycle → counter 01+bonus, no FLAG; i_win in RUN → WON and counter frozen.
- Reset asserted mid-RUN → next cycle: state IDLE, counter 00, o_turn=0, o_drv_led=0.
